// File: rtl/bcd_mod_counter_pkg.sv
// Shared BCD types and constant helpers for the modulo digit counter.
// Helpers work on a fixed wide vector; callers truncate to their own width.
package bcd_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int WIDE_W     = 4 * MAX_DIGITS;

  typedef logic [3:0]        bcd_digit_t;
  typedef logic [WIDE_W-1:0] bcd_wide_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Binary to packed BCD, digit 0 in the low nibble.
  function automatic bcd_wide_t to_bcd(int value, int digits);
    bcd_wide_t r = '0;
    int        v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v           = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(bcd_wide_t v, int digits);
    logic ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/status bundle of one counter stage; the driver owns master,
// the counter owns slave.
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);

  logic                  en;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  inc;
  logic                  dir;
  logic [4*DIGITS-1:0]   cnt;
  logic                  co;
  logic                  load_err;

  modport master (
    output en, clr, load, load_val, inc, dir,
    input  cnt, co, load_err
  );

  modport slave (
    input  en, clr, load, load_val, inc, dir,
    output cnt, co, load_err
  );

endinterface

// File: rtl/bcd_mod_counter_digit_step.sv
// One BCD digit of the increment/decrement ripple: steps the digit when
// cin is set and reports carry (9->0) or borrow (0->9) on cout.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       dir,
  input  logic       cin,
  output bcd_digit_t next_digit,
  output logic       cout
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (dir == DIR_DOWN) begin
        if (digit == 4'd0) begin
          next_digit = 4'd9;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end else begin
        if (digit == 4'd9) begin
          next_digit = 4'd0;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// N-digit BCD modulo counter with up/down, parallel load, synchronous clear
// and a combinational carry/borrow for same-cycle cascading.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24,
  parameter int INITIAL = 0
) (
  input logic              clk,
  input logic              rstn,
  bcd_mod_counter_if.slave bus
);

  localparam int              W        = 4 * DIGITS;
  localparam logic [W-1:0]    TERM_UP  = W'(to_bcd(MODULUS - 1, DIGITS));
  localparam logic [W-1:0]    INIT_BCD = W'(to_bcd(INITIAL, DIGITS));

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("bcd_mod_counter: DIGITS must be 1..%0d", MAX_DIGITS);
  end
  if (MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be 2..10**DIGITS");
  end
  if (INITIAL < 0 || INITIAL >= MODULUS) begin : g_bad_initial
    $error("bcd_mod_counter: INITIAL must be below MODULUS");
  end

  logic [W-1:0]    cnt_q;
  logic            load_err_q;
  logic [W-1:0]    stepped;
  logic [DIGITS:0] carry;
  logic            terminal;
  logic            fire;
  logic            load_ok;
  logic [W-1:0]    count_next;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (cnt_q[4*i +: 4]),
      .dir        (bus.dir),
      .cin        (carry[i]),
      .next_digit (stepped[4*i +: 4]),
      .cout       (carry[i+1])
    );
  end

  // A borrow out of the top digit happens exactly when every digit is 0.
  assign terminal = (bus.dir == DIR_DOWN) ? carry[DIGITS] : (cnt_q == TERM_UP);

  assign count_next = !terminal              ? stepped :
                      (bus.dir == DIR_DOWN)  ? TERM_UP : '0;

  // For all-valid BCD, vector order equals numeric order, so no binary conversion.
  assign load_ok = bcd_valid(bcd_wide_t'(bus.load_val), DIGITS) && (bus.load_val <= TERM_UP);

  assign fire = bus.en & bus.inc;

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rstn) begin
      cnt_q      <= INIT_BCD;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (bus.clr) begin
        cnt_q <= INIT_BCD;
      end else if (bus.load) begin
        if (load_ok) cnt_q      <= bus.load_val;
        else         load_err_q <= 1'b1;
      end else if (fire) begin
        cnt_q <= count_next;
      end
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.load_err = load_err_q;
  assign bus.co       = rstn & fire & ~bus.clr & ~bus.load & terminal;

endmodule
